// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, funct encodings and sequencer state for the vector ALU path
package vec_pkg;

  localparam int LANES   = 8;
  localparam int GRP_MAX = 4;

  localparam logic [5:0] LANES6   = 6'(LANES);
  localparam logic [5:0] VLEN_MAX = 6'(LANES * GRP_MAX);

  localparam logic [5:0] F_ADD_V = 6'b110000;
  localparam logic [5:0] F_SUB_V = 6'b110001;
  localparam logic [5:0] F_AND_V = 6'b110010;
  localparam logic [5:0] F_OR_V  = 6'b110011;
  localparam logic [5:0] F_XOR_V = 6'b110100;
  localparam logic [5:0] F_MUL_V = 6'b110101;

  localparam logic [1:0] ALU_OP_VEC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  function automatic logic funct_legal(input logic [5:0] f);
    return (f >= F_ADD_V) && (f <= F_MUL_V);
  endfunction

endpackage

// File: rtl/vec_lane_mask.sv
// rtl/vec_lane_mask.sv - remaining element count to per-lane write-enable mask
module vec_lane_mask
  import vec_pkg::*;
(
  input  logic [5:0] i_rem,
  output logic [7:0] o_mask
);

  // A partial tail group enables only its low i_rem lanes.
  always_comb begin
    o_mask = 8'hFF;
    if (i_rem < LANES6) begin
      o_mask = (8'h01 << i_rem[2:0]) - 8'h01;
    end
  end

endmodule

// File: rtl/vec_exe_seq.sv
// rtl/vec_exe_seq.sv - strip-mining sequencer driving regfile reads, ALU op and lane-masked write-back
module vec_exe_seq
  import vec_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_funct,
  input  logic [2:0] in_vd,
  input  logic [2:0] in_vs1,
  input  logic [2:0] in_vs2,
  input  logic [5:0] in_vlen,
  output logic [4:0] rd_vs1,
  output logic [4:0] rd_vs2,
  output logic [5:0] alu_funct,
  output logic [1:0] alu_op,
  output logic       wb_en,
  output logic [4:0] wb_addr,
  output logic [7:0] wb_mask,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  // Cycles spent in MWAIT after the RUN cycle: the group occupies MUL_LAT cycles in total.
  localparam logic [3:0] CNT_INIT   = (MUL_LAT >= 2) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam bit         MUL_DIRECT = (MUL_LAT == 1);

  state_t     r_state;
  logic [5:0] r_funct;
  logic [2:0] r_vd;
  logic [2:0] r_vs1;
  logic [2:0] r_vs2;
  logic [1:0] r_grp;
  logic [5:0] r_rem;
  logic [3:0] r_cnt;
  logic       r_done;
  logic       r_illegal;

  logic       w_active;
  logic       w_mul;
  logic       w_wb;
  logic       w_last;
  logic [7:0] w_mask;

  assign w_active = (r_state != ST_IDLE);
  assign w_mul    = (r_funct == F_MUL_V);
  assign w_last   = (r_rem <= LANES6);
  assign w_wb     = ((r_state == ST_RUN) && (!w_mul || MUL_DIRECT)) ||
                    ((r_state == ST_MWAIT) && (r_cnt == 4'd0));

  vec_lane_mask u_lane_mask (
    .i_rem  (r_rem),
    .o_mask (w_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_funct   <= '0;
      r_vd      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_grp     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_funct <= in_funct;
            r_vd    <= in_vd;
            r_vs1   <= in_vs1;
            r_vs2   <= in_vs2;
            r_rem   <= in_vlen;
            r_grp   <= '0;
            r_cnt   <= '0;
            if (!funct_legal(in_funct) || (in_vlen > VLEN_MAX)) begin
              r_illegal <= 1'b1;
            end else if (in_vlen == 6'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN, ST_MWAIT: begin
          if (w_wb) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_grp   <= '0;
              r_rem   <= '0;
            end else begin
              r_state <= ST_RUN;
              r_grp   <= r_grp + 2'd1;
              r_rem   <= r_rem - LANES6;
            end
          end else if (r_state == ST_RUN) begin
            r_state <= ST_MWAIT;
            r_cnt   <= CNT_INIT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = !w_active;
  assign busy      = w_active;
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign rd_vs1    = w_active ? {r_vs1, r_grp} : 5'd0;
  assign rd_vs2    = w_active ? {r_vs2, r_grp} : 5'd0;
  assign alu_funct = w_active ? r_funct : 6'd0;
  assign alu_op    = w_active ? ALU_OP_VEC : 2'b00;
  assign wb_en     = w_wb;
  assign wb_addr   = w_wb ? {r_vd, r_grp} : 5'd0;
  assign wb_mask   = w_wb ? w_mask : 8'd0;

endmodule

// File: tb/tb_vec_exe_seq.sv
// tb/tb_vec_exe_seq.sv - randomized and directed bench for vec_exe_seq against a cycle-trace model
module tb_vec_exe_seq;

  localparam int MUL_LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_funct = '0;
  logic [2:0] in_vd = '0;
  logic [2:0] in_vs1 = '0;
  logic [2:0] in_vs2 = '0;
  logic [5:0] in_vlen = '0;
  logic [4:0] rd_vs1;
  logic [4:0] rd_vs2;
  logic [5:0] alu_funct;
  logic [1:0] alu_op;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic [7:0] wb_mask;
  logic       busy;
  logic       done;
  logic       illegal;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [35:0] IDLE_VEC = {1'b1, 35'd0};

  vec_exe_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_vlen(in_vlen), .rd_vs1(rd_vs1), .rd_vs2(rd_vs2), .alu_funct(alu_funct),
    .alu_op(alu_op), .wb_en(wb_en), .wb_addr(wb_addr), .wb_mask(wb_mask),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] observed();
    return {in_ready, busy, done, illegal, alu_op, alu_funct, rd_vs1, rd_vs2,
            wb_en, wb_addr, wb_mask};
  endfunction

  // Issue one instruction at the current negedge and check every cycle up to its done/illegal pulse.
  task automatic run_instr(input logic [5:0] f, input logic [2:0] vd, input logic [2:0] vs1,
                           input logic [2:0] vs2, input logic [5:0] vl, input bit hold,
                           input string name);
    bit          bad;
    bit          mul;
    int          ng;
    int          t_end;
    int          g;
    int          n;
    bit          wb;
    logic [1:0]  gg;
    logic [7:0]  mask;
    logic [35:0] exp_v;
    logic [35:0] act_v;
    bad   = (f < 6'h30) || (f > 6'h35) || (vl > 6'd32);
    mul   = (f == 6'h35);
    ng    = (int'(vl) + 7) / 8;
    t_end = (bad || vl == 0) ? 1 : (mul ? ng * MUL_LAT + 1 : ng + 1);
    in_valid = 1'b1;
    in_funct = f; in_vd = vd; in_vs1 = vs1; in_vs2 = vs2; in_vlen = vl;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    for (int k = 1; k <= t_end; k++) begin
      @(negedge clk);
      if (k < t_end) begin
        g    = mul ? (k - 1) / MUL_LAT : k - 1;
        wb   = mul ? ((k % MUL_LAT) == 0) : 1'b1;
        n    = int'(vl) - g * 8;
        if (n > 8) n = 8;
        mask = 8'((1 << n) - 1);
        gg   = 2'(g);
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'b10, f, {vs1, gg}, {vs2, gg},
                 wb, wb ? {vd, gg} : 5'd0, wb ? mask : 8'd0};
      end else begin
        exp_v = {1'b1, 1'b0, !bad, bad, 32'd0};
      end
      act_v = observed();
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, act_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (observed() !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", observed(), IDLE_VEC);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(6'h30, 3'd1, 3'd2, 3'd3, 6'd32, 1'b0, "add_v_32");
    run_instr(6'h31, 3'd4, 3'd5, 3'd6, 6'd13, 1'b0, "sub_v_13");
    run_instr(6'h35, 3'd7, 3'd0, 3'd1, 6'd16, 1'b0, "mul_v_16");
    run_instr(6'h35, 3'd2, 3'd3, 3'd4, 6'd9,  1'b0, "mul_v_9");
    run_instr(6'h32, 3'd3, 3'd3, 3'd3, 6'd1,  1'b0, "and_v_1");
    run_instr(6'h33, 3'd6, 3'd1, 3'd2, 6'd8,  1'b0, "or_v_8");
    run_instr(6'h30, 3'd1, 3'd1, 3'd1, 6'd0,  1'b0, "vlen_zero");
    run_instr(6'h3F, 3'd1, 3'd2, 3'd3, 6'd8,  1'b0, "bad_funct");
    run_instr(6'h2F, 3'd1, 3'd2, 3'd3, 6'd8,  1'b0, "funct_below");
    run_instr(6'h30, 3'd1, 3'd2, 3'd3, 6'd40, 1'b0, "vlen_40");
    run_instr(6'h34, 3'd5, 3'd6, 3'd7, 6'd33, 1'b0, "vlen_33");
  endtask

  task automatic test_back_to_back();
    run_instr(6'h34, 3'd2, 3'd4, 3'd6, 6'd20, 1'b1, "b2b_hold_xor");
    run_instr(6'h35, 3'd1, 3'd3, 3'd5, 6'd24, 1'b1, "b2b_hold_mul");
    run_instr(6'h31, 3'd7, 3'd6, 3'd5, 6'd31, 1'b0, "b2b_last_sub");
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [5:0] vl;
    int         sel;
    bit         hold;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel < 6)       f = 6'h30 + 6'(sel);
      else if (sel == 6) f = 6'h3F;
      else               f = 6'($urandom);
      vl   = 6'($urandom_range(0, 40));
      hold = (i != 39) && ($urandom_range(0, 1) == 1);
      run_instr(f, 3'($urandom), 3'($urandom), 3'($urandom), vl, hold, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp_v;
    in_valid = 1'b1;
    in_funct = 6'h34; in_vd = 3'd3; in_vs1 = 3'd1; in_vs2 = 3'd2; in_vlen = 6'd32;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 6'h34, 5'd4, 5'd8, 1'b1, 5'd12, 8'hFF};
    n_vec++;
    if (observed() !== exp_v) begin
      n_bad++;
      $display("FAIL reset_mid_first_group: got %h expected %h", observed(), exp_v);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (observed() !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL reset_mid_after cycle %0d: got %h expected %h", k, observed(), IDLE_VEC);
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    run_instr(6'h30, 3'd1, 3'd2, 3'd3, 6'd17, 1'b0, "after_reset_add");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
